// File: rtl/fdtd_mem_wt_arb.sv
// Round-robin arbiter sharing the FDTD memory writer's single word-write port
// between NUM_REQ requesters; latches the winner and holds the request until granted.
module fdtd_mem_wt_arb #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32,
    parameter int IDW        = $clog2(NUM_REQ)
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] word_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic                          wt_req_o,
    output logic [ADDR_WIDTH-1:0]         wt_word_addr_o,
    output logic [DATA_WIDTH-1:0]         wt_data_o,
    input  logic                          wt_gnt_i,
    output logic                          busy_o,
    output logic [IDW-1:0]                cur_id_o,
    output logic [CNT_WIDTH-1:0]          wr_cnt_o,
    output logic                          err_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [IDW-1:0]          r_ptr;
    logic [IDW-1:0]          r_cur_id;
    logic                    r_wt_req;
    logic                    r_busy;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic                    r_err;

    logic                    w_found;
    logic [IDW-1:0]          w_win;
    logic                    w_start;
    logic                    w_complete;
    logic                    w_idle_gnt;
    logic [IDW-1:0]          w_ptr_next;
    logic [ADDR_WIDTH-1:0]   w_win_addr;
    logic [DATA_WIDTH-1:0]   w_win_data;

    // Scan upward from the pointer, wrapping at NUM_REQ-1, and take the first request.
    always_comb begin
        logic [IDW:0] idx;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, r_ptr} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(NUM_REQ)) begin
                idx = idx - (IDW+1)'(NUM_REQ);
            end
            if (!w_found && req_i[idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = idx[IDW-1:0];
            end
        end
    end

    assign w_win_addr = word_addr_i[w_win*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_win_data = data_i[w_win*DATA_WIDTH +: DATA_WIDTH];

    assign w_start    = (r_state == ST_IDLE) && w_found;
    assign w_complete = (r_state == ST_BUSY) && wt_gnt_i;
    assign w_idle_gnt = (r_state == ST_IDLE) && wt_gnt_i;
    assign w_ptr_next = (r_cur_id == IDW'(NUM_REQ - 1)) ? '0 : r_cur_id + 1'b1;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (wt_gnt_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Latched transaction: held constant for the whole BUSY phase.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wt_req <= 1'b0;
            r_busy   <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_cur_id <= '0;
        end else if (w_start) begin
            r_wt_req <= 1'b1;
            r_busy   <= 1'b1;
            r_addr   <= w_win_addr;
            r_data   <= w_win_data;
            r_cur_id <= w_win;
        end else if (w_complete) begin
            r_wt_req <= 1'b0;
            r_busy   <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (w_complete) begin
            r_ptr <= w_ptr_next;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A downstream grant with nothing outstanding is a protocol violation.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_err <= 1'b0;
        end else if (w_idle_gnt) begin
            r_err <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
            assign gnt_o[gi] = w_complete && (r_cur_id == IDW'(gi));
        end
    endgenerate

    assign wt_req_o       = r_wt_req;
    assign wt_word_addr_o = r_addr;
    assign wt_data_o      = r_data;
    assign busy_o         = r_busy;
    assign cur_id_o       = r_cur_id;
    assign wr_cnt_o       = r_cnt;
    assign err_o          = r_err;

endmodule
